// File: rtl/axis_pkt_framer_pkg.sv
// ---------------------------------------------------------------------------
// axis_pkt_framer_pkg
//   Shared definitions for the AXI-Stream packet framer:
//     - state_t     : FSM state encodings (3-bit)
//     - FRAME_OVH   : non-payload beats added per frame (header + trailer(s))
//   Configuration macro: AXIS_FRAMER_CSUM_EN
//     defined   -> checksum trailer state exists, FRAME_OVH = 3
//     undefined -> count trailer only,            FRAME_OVH = 2
// ---------------------------------------------------------------------------
package axis_pkt_framer_pkg;

`ifdef AXIS_FRAMER_CSUM_EN
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HDR      = 3'd1,
        ST_BODY     = 3'd2,
        ST_TRL_CNT  = 3'd3,
        ST_TRL_CSUM = 3'd4
    } state_t;

    localparam int FRAME_OVH = 3;
`else
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HDR      = 3'd1,
        ST_BODY     = 3'd2,
        ST_TRL_CNT  = 3'd3
    } state_t;

    localparam int FRAME_OVH = 2;
`endif

endpackage : axis_pkt_framer_pkg

// File: rtl/axis_pkt_framer.sv
// ---------------------------------------------------------------------------
// axis_pkt_framer
//   Takes whole packets from an upstream packet-mode AXI-S FIFO and re-emits
//   each one as a frame: one header beat carrying a sequence number, the
//   payload unchanged, then a trailer carrying the payload beat count
//   (saturating) and, optionally, an XOR checksum of the payload.
//   One registered output stage, full throughput in the body, no payload
//   storage.
//
// Configuration macro: AXIS_FRAMER_CSUM_EN (adds the checksum trailer beat;
//   tlast then moves from the count beat to the checksum beat).
//
// Parameters
//   DSIZE     data width of s_tdata / m_tdata
//   CNTW      width of pkt_count
//   SEQ_INIT  sequence number loaded at reset (low DSIZE bits used)
//
// Ports
//   aclk       in   clock, rising edge
//   aresetn    in   asynchronous active-low reset
//   s_tdata    in   payload data
//   s_tvalid   in   payload valid
//   s_tlast    in   last payload beat of a packet
//   s_tready   out  payload accepted on s_tvalid & s_tready
//   m_tdata    out  framed data (registered)
//   m_tvalid   out  framed valid (registered)
//   m_tlast    out  last beat of frame (registered)
//   m_tready   in   downstream ready
//   pkt_count  out  completed frames, wraps modulo 2^CNTW
//   busy       out  FSM not idle
// ---------------------------------------------------------------------------
module axis_pkt_framer
    import axis_pkt_framer_pkg::*;
#(
    parameter int DSIZE    = 8,
    parameter int CNTW     = 16,
    parameter int SEQ_INIT = 0
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic [DSIZE-1:0] s_tdata,
    input  logic             s_tvalid,
    input  logic             s_tlast,
    output logic             s_tready,
    output logic [DSIZE-1:0] m_tdata,
    output logic             m_tvalid,
    output logic             m_tlast,
    input  logic             m_tready,
    output logic [CNTW-1:0]  pkt_count,
    output logic             busy
);

    localparam logic [DSIZE-1:0] SEQ_RST = DSIZE'(SEQ_INIT);
    localparam logic [DSIZE-1:0] ONE_D   = DSIZE'(1);
    localparam logic [CNTW-1:0]  ONE_C   = CNTW'(1);

    state_t           state_q, state_d;
    logic [DSIZE-1:0] data_q,  data_d;
    logic             valid_q, valid_d;
    logic             last_q,  last_d;
    logic [DSIZE-1:0] seq_q,   seq_d;
    logic [DSIZE-1:0] bcnt_q,  bcnt_d;
    logic [CNTW-1:0]  cnt_q,   cnt_d;
`ifdef AXIS_FRAMER_CSUM_EN
    logic [DSIZE-1:0] csum_q,  csum_d;
`endif

    // Output register may take a new beat when it is empty or being drained.
    logic ld;
    assign ld = !valid_q || m_tready;

    assign s_tready  = (state_q == ST_BODY) && ld;
    assign busy      = (state_q != ST_IDLE);
    assign m_tdata   = data_q;
    assign m_tvalid  = valid_q;
    assign m_tlast   = last_q;
    assign pkt_count = cnt_q;

    // ------------------------------------------------------------------
    // Next-state / next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets its hold value first so no path through
        // the case statement leaves one unassigned (which would infer a latch).
        state_d = state_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        seq_d   = seq_q;
        bcnt_d  = bcnt_q;
        cnt_d   = cnt_q;
`ifdef AXIS_FRAMER_CSUM_EN
        csum_d  = csum_q;
`endif

        // A load slot with nothing new to present empties the register;
        // the branches below override this when they do produce a beat.
        if (ld) begin
            valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                // Packet is only observed here; its first beat is taken in BODY.
                if (s_tvalid) begin
                    state_d = ST_HDR;
                end
            end

            ST_HDR: begin
                if (ld) begin
                    data_d  = seq_q;
                    last_d  = 1'b0;
                    valid_d = 1'b1;
                    bcnt_d  = '0;
`ifdef AXIS_FRAMER_CSUM_EN
                    csum_d  = '0;
`endif
                    state_d = ST_BODY;
                end
            end

            ST_BODY: begin
                if (s_tvalid && ld) begin
                    data_d  = s_tdata;
                    last_d  = 1'b0;
                    valid_d = 1'b1;
                    if (bcnt_q != '1) begin
                        bcnt_d = bcnt_q + ONE_D;
                    end
`ifdef AXIS_FRAMER_CSUM_EN
                    csum_d  = csum_q ^ s_tdata;
`endif
                    if (s_tlast) begin
                        state_d = ST_TRL_CNT;
                    end
                end
            end

            ST_TRL_CNT: begin
                if (ld) begin
                    data_d  = bcnt_q;
                    valid_d = 1'b1;
`ifdef AXIS_FRAMER_CSUM_EN
                    last_d  = 1'b0;
                    state_d = ST_TRL_CSUM;
`else
                    last_d  = 1'b1;
                    seq_d   = seq_q + ONE_D;
                    cnt_d   = cnt_q + ONE_C;
                    state_d = ST_IDLE;
`endif
                end
            end

`ifdef AXIS_FRAMER_CSUM_EN
            ST_TRL_CSUM: begin
                if (ld) begin
                    data_d  = csum_q;
                    last_d  = 1'b1;
                    valid_d = 1'b1;
                    seq_d   = seq_q + ONE_D;
                    cnt_d   = cnt_q + ONE_C;
                    state_d = ST_IDLE;
                end
            end
`endif

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            seq_q   <= SEQ_RST;
            bcnt_q  <= '0;
            cnt_q   <= '0;
`ifdef AXIS_FRAMER_CSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            seq_q   <= seq_d;
            bcnt_q  <= bcnt_d;
            cnt_q   <= cnt_d;
`ifdef AXIS_FRAMER_CSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

endmodule : axis_pkt_framer

// File: tb/tb_axis_pkt_framer.sv
// ---------------------------------------------------------------------------
// tb_axis_pkt_framer
//   Directed self-checking bench for axis_pkt_framer (DSIZE=8, SEQ_INIT=0).
//   Works with or without AXIS_FRAMER_CSUM_EN defined.
//   All stimulus and checking runs in one initial block, stepped at the
//   falling clock edge; output beats are captured when m_tvalid & m_tready.
// ---------------------------------------------------------------------------
module tb_axis_pkt_framer;

`ifdef AXIS_FRAMER_CSUM_EN
    localparam int OVH = 3;
`else
    localparam int OVH = 2;
`endif

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [7:0]  s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tlast = 1'b0;
    logic        s_tready;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready = 1'b1;
    logic [15:0] pkt_count;
    logic        busy;

    axis_pkt_framer #(.DSIZE(8), .CNTW(16), .SEQ_INIT(0)) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .s_tdata   (s_tdata),
        .s_tvalid  (s_tvalid),
        .s_tlast   (s_tlast),
        .s_tready  (s_tready),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .m_tlast   (m_tlast),
        .m_tready  (m_tready),
        .pkt_count (pkt_count),
        .busy      (busy)
    );

    always #5 aclk = ~aclk;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc   = 0;
    bit         tog   = 1'b0;
    logic [7:0] pkt_buf [0:511];
    logic [7:0] cap_d [$];
    logic       cap_l [$];
    int         cap_c [$];
    bit         prev_stall = 1'b0;
    logic [7:0] snap_d;
    logic       snap_l;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock step: wait for the falling edge, update m_tready, run the
    // stall checks and capture any beat that will transfer on the next rise.
    task automatic tick();
        @(negedge aclk);
        if (tog) m_tready = ~m_tready;
        #1;
        cyc++;
        if (prev_stall) begin
            check("stall_hold_valid", {31'd0, m_tvalid}, 32'd1);
            check("stall_hold_data", {24'd0, m_tdata}, {24'd0, snap_d});
            check("stall_hold_last", {31'd0, m_tlast}, {31'd0, snap_l});
        end
        if (m_tvalid && !m_tready)
            check("stall_s_tready", {31'd0, s_tready}, 32'd0);
        if (m_tvalid && m_tready) begin
            cap_d.push_back(m_tdata);
            cap_l.push_back(m_tlast);
            cap_c.push_back(cyc);
        end
        prev_stall = m_tvalid && !m_tready;
        snap_d = m_tdata;
        snap_l = m_tlast;
    endtask

    task automatic clear_cap();
        cap_d.delete();
        cap_l.delete();
        cap_c.delete();
    endtask

    task automatic apply_reset();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        aresetn  = 1'b0;
        tick();
        tick();
        aresetn = 1'b1;
        tick();
        clear_cap();
    endtask

    // Send n beats from pkt_buf[off..]; s_tlast on the final beat if last_end.
    // gap: number of idle cycles inserted after each accepted beat.
    task automatic send_pkt(input int off, input int n, input bit last_end, input int gap);
        for (int i = 0; i < n; i++) begin
            int  k;
            bit  acc;
            s_tvalid = 1'b1;
            s_tdata  = pkt_buf[off+i];
            s_tlast  = last_end && (i == n - 1);
            k = 0;
            forever begin
                acc = s_tready;
                tick();
                if (acc) break;
                k++;
                if (k > 50) begin
                    check("send_timeout", 32'd0, 32'd1);
                    break;
                end
            end
            if (gap > 0 && i != n - 1) begin
                s_tvalid = 1'b0;
                for (int g = 0; g < gap; g++) tick();
            end
        end
    endtask

    task automatic drain(input int n);
        int k;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        k = 0;
        while (cap_d.size() < n && k < 2000) begin
            tick();
            k++;
        end
        check("drain_beats", cap_d.size(), n);
    endtask

    // Compare one captured frame against header sq and payload pkt_buf[poff..].
    task automatic check_frame(input string tag, input int base, input logic [7:0] sq,
                               input int poff, input int n);
        logic [7:0] cnt;
        logic [7:0] cs;
        cnt = (n > 255) ? 8'hFF : n[7:0];
        cs  = '0;
        check({tag, ".hdr"}, {24'd0, cap_d[base]}, {24'd0, sq});
        check({tag, ".hdr_last"}, {31'd0, cap_l[base]}, 32'd0);
        for (int j = 0; j < n; j++) begin
            cs = cs ^ pkt_buf[poff+j];
            check($sformatf("%s.pay%0d", tag, j), {24'd0, cap_d[base+1+j]}, {24'd0, pkt_buf[poff+j]});
            check($sformatf("%s.pay%0d_last", tag, j), {31'd0, cap_l[base+1+j]}, 32'd0);
        end
        check({tag, ".cnt"}, {24'd0, cap_d[base+1+n]}, {24'd0, cnt});
`ifdef AXIS_FRAMER_CSUM_EN
        check({tag, ".cnt_last"}, {31'd0, cap_l[base+1+n]}, 32'd0);
        check({tag, ".csum"}, {24'd0, cap_d[base+2+n]}, {24'd0, cs});
        check({tag, ".csum_last"}, {31'd0, cap_l[base+2+n]}, 32'd1);
`else
        check({tag, ".cnt_last"}, {31'd0, cap_l[base+1+n]}, 32'd1);
`endif
    endtask

    initial begin
        int c0;

        // ---------------- reset state ----------------
        #1;
        check("rst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
        check("rst_m_tdata", {24'd0, m_tdata}, 32'd0);
        check("rst_m_tlast", {31'd0, m_tlast}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_pkt_count", {16'd0, pkt_count}, 32'd0);
        check("rst_s_tready", {31'd0, s_tready}, 32'd0);
        apply_reset();

        // ---------------- 1: 3-beat packet, latency ----------------
        pkt_buf[0] = 8'h11; pkt_buf[1] = 8'h22; pkt_buf[2] = 8'h33;
        c0 = cyc;
        send_pkt(0, 3, 1'b1, 0);
        drain(3 + OVH);
        check_frame("t1", 0, 8'h00, 0, 3);
        check("t1_latency", cap_c[0] - c0, 32'd2);
        check("t1_pkt_count", {16'd0, pkt_count}, 32'd1);
        tick();
        check("t1_idle_busy", {31'd0, busy}, 32'd0);
        check("t1_idle_valid", {31'd0, m_tvalid}, 32'd0);

        // ---------------- 2: back-to-back 1-beat packets ----------------
        apply_reset();
        pkt_buf[0] = 8'hAA; pkt_buf[1] = 8'hBB;
        send_pkt(0, 1, 1'b1, 0);
        send_pkt(1, 1, 1'b1, 0);
        drain(2 * (1 + OVH));
        check_frame("t2a", 0, 8'h00, 0, 1);
        check_frame("t2b", 1 + OVH, 8'h01, 1, 1);
        check("t2_gap", cap_c[1+OVH] - cap_c[OVH], 32'd2);
        check("t2_pkt_count", {16'd0, pkt_count}, 32'd2);

        // ---------------- 3: m_tready toggling, then s_tvalid bubbles -------
        apply_reset();
        pkt_buf[0] = 8'h41; pkt_buf[1] = 8'h42; pkt_buf[2] = 8'h43; pkt_buf[3] = 8'h44;
        tog = 1'b1;
        send_pkt(0, 4, 1'b1, 0);
        drain(4 + OVH);
        tog = 1'b0;
        m_tready = 1'b1;
        check_frame("t3", 0, 8'h00, 0, 4);
        tick();
        clear_cap();
        pkt_buf[4] = 8'h0F; pkt_buf[5] = 8'hF0; pkt_buf[6] = 8'h5A;
        send_pkt(4, 3, 1'b1, 2);
        drain(3 + OVH);
        check_frame("t3b", 0, 8'h01, 4, 3);

        // ---------------- 4: 300-beat packet, count saturation ----------------
        apply_reset();
        for (int i = 0; i < 300; i++) pkt_buf[i] = i[7:0];
        send_pkt(0, 300, 1'b1, 0);
        drain(300 + OVH);
        check_frame("t4", 0, 8'h00, 0, 300);
        pkt_buf[300] = 8'h77;
        send_pkt(300, 1, 1'b1, 0);
        drain(300 + OVH + 1 + OVH);
        check_frame("t4n", 300 + OVH, 8'h01, 300, 1);

        // ---------------- 5: 256 frames, sequence wrap ----------------
        apply_reset();
        for (int f = 0; f < 257; f++) pkt_buf[f] = f[7:0] ^ 8'h3C;
        for (int f = 0; f < 256; f++) send_pkt(f, 1, 1'b1, 0);
        drain(256 * (1 + OVH));
        check("t5_pkt_count", {16'd0, pkt_count}, 32'd256);
        check_frame("t5_f255", 255 * (1 + OVH), 8'hFF, 255, 1);
        send_pkt(256, 1, 1'b1, 0);
        drain(257 * (1 + OVH));
        check_frame("t5_f256", 256 * (1 + OVH), 8'h00, 256, 1);

        // ---------------- 6: reset mid-frame ----------------
        apply_reset();
        pkt_buf[0] = 8'h99; pkt_buf[1] = 8'h01; pkt_buf[2] = 8'h02; pkt_buf[3] = 8'h5C;
        send_pkt(0, 1, 1'b1, 0);
        drain(1 + OVH);
        check_frame("t6_pre", 0, 8'h00, 0, 1);
        tick();
        send_pkt(1, 2, 1'b0, 0);
        check("t6_busy_before", {31'd0, busy}, 32'd1);
        s_tvalid = 1'b0;
        aresetn  = 1'b0;
        #1;
        check("t6_m_tvalid", {31'd0, m_tvalid}, 32'd0);
        check("t6_m_tdata", {24'd0, m_tdata}, 32'd0);
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_pkt_count", {16'd0, pkt_count}, 32'd0);
        tick();
        aresetn = 1'b1;
        tick();
        clear_cap();
        send_pkt(3, 1, 1'b1, 0);
        drain(1 + OVH);
        check_frame("t6_post", 0, 8'h00, 3, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_axis_pkt_framer
